fetch_sequencer: RTL and testbench

- Instruction-fetch control stage for the MIPS pipeline.
- Owns the PC and issues one read request to all four instruction byte-lane memories in parallel.
- Assembles the four returned bytes into a 32-bit word and presents it to IF/ID over a valid/ready handshake.
- Handles stall, branch/jump redirect and squash of in-flight fetches.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_sequencer_if.sv | 33 +++
 rtl/fetch_lane_assembler.sv | 45 ++++
 rtl/fetch_sequencer.sv | 125 ++++++++++++
 tb/tb_fetch_sequencer.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   fetch_state_t : sequencer FSM encoding
//   INSTR_W / LANE_W / NUM_LANES : word and byte-lane geometry
//   PC_INC / LANE_ALL_VALID : PC step and the "every lane answered" mask
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    VALID = 2'd3
  } fetch_state_t;

  localparam int INSTR_W   = 32;
  localparam int LANE_W    = 8;
  localparam int NUM_LANES = 4;
  localparam int PC_INC    = 4;

  localparam logic [NUM_LANES-1:0] LANE_ALL_VALID = 4'hF;

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: lane-memory read bus plus IF/ID output handshake.
//   mem_rd_en, mem_rd_addr          : read request to all four lane memories
//   mem_data_b3..b0, mem_valid      : per-lane response bytes and valids
//   out_valid, out_ready            : valid/ready handshake toward IF/ID
//   out_instr, out_pc               : assembled word and its byte address
// master = fetch sequencer side, slave = memories / IF/ID side.
interface fetch_sequencer_if #(
  parameter int ADDR_W = 11
);

  logic                                 mem_rd_en;
  logic [ADDR_W-3:0]                    mem_rd_addr;
  logic [fetch_pkg::LANE_W-1:0]         mem_data_b3;
  logic [fetch_pkg::LANE_W-1:0]         mem_data_b2;
  logic [fetch_pkg::LANE_W-1:0]         mem_data_b1;
  logic [fetch_pkg::LANE_W-1:0]         mem_data_b0;
  logic [fetch_pkg::NUM_LANES-1:0]      mem_valid;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [fetch_pkg::INSTR_W-1:0]        out_instr;
  logic [ADDR_W-1:0]                    out_pc;

  modport master (
    output mem_rd_en, mem_rd_addr, out_valid, out_instr, out_pc,
    input  mem_data_b3, mem_data_b2, mem_data_b1, mem_data_b0, mem_valid, out_ready
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr, out_valid, out_instr, out_pc,
    output mem_data_b3, mem_data_b2, mem_data_b1, mem_data_b0, mem_valid, out_ready
  );

endinterface

// File: rtl/fetch_lane_assembler.sv
// fetch_lane_assembler: registers the four lane bytes into one instruction
// word and flags non-uniform lane valids.
//   clk, rst_n         : clock, async active-low reset
//   capture            : load instr <= {b3,b2,b1,b0}
//   check              : response cycle; evaluate lane_valid uniformity
//   b3..b0, lane_valid : lane data and per-lane valid
//   all_valid          : every lane answered (combinational)
//   instr              : registered instruction word
//   lane_err           : sticky, set when some but not all lanes answered
module fetch_lane_assembler
  import fetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 capture,
  input  logic                 check,
  input  logic [LANE_W-1:0]    b3,
  input  logic [LANE_W-1:0]    b2,
  input  logic [LANE_W-1:0]    b1,
  input  logic [LANE_W-1:0]    b0,
  input  logic [NUM_LANES-1:0] lane_valid,
  output logic                 all_valid,
  output logic [INSTR_W-1:0]   instr,
  output logic                 lane_err
);

  logic non_uniform;

  assign all_valid   = (lane_valid == LANE_ALL_VALID);
  assign non_uniform = (lane_valid != '0) && !all_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr    <= '0;
      lane_err <= 1'b0;
    end else begin
      if (capture)
        instr <= {b3, b2, b1, b0};
      // A lane fault is reported even if the data would be dropped anyway.
      if (check && non_uniform)
        lane_err <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, issues one read per word to the four lane
// memories, and hands assembled words to IF/ID over valid/ready.
//   clk, rst_n                 : clock, async active-low reset
//   en                         : fetch enable (parks in IDLE when low)
//   redirect_valid/redirect_pc : load new PC, squash in-flight fetch
//   bus (master)               : lane-memory request/response + IF/ID output
//   lane_err, align_err        : sticky error flags
//
// state | meaning
// IDLE  | parked, no request outstanding
// FETCH | mem_rd_en high, request for pc issued
// WAIT  | lane data visible, capture/discard decision
// VALID | word presented to IF/ID until accepted
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 11,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  fetch_sequencer_if.master  bus,
  output logic               lane_err,
  output logic               align_err
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              drop_q, drop_d;
  logic              out_valid_d;
  logic              capture;
  logic              check;
  logic              align_set;
  logic              all_valid;

  fetch_lane_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .capture    (capture),
    .check      (check),
    .b3         (bus.mem_data_b3),
    .b2         (bus.mem_data_b2),
    .b1         (bus.mem_data_b1),
    .b0         (bus.mem_data_b0),
    .lane_valid (bus.mem_valid),
    .all_valid  (all_valid),
    .instr      (bus.out_instr),
    .lane_err   (lane_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (en && !redirect_valid) state_d = FETCH;
      FETCH: state_d = WAIT;
      WAIT:  state_d = (all_valid && !drop_q && !redirect_valid) ? VALID : FETCH;
      VALID: begin
        if (redirect_valid)     state_d = FETCH;
        else if (bus.out_ready) state_d = en ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d        = pc_q;
    drop_d      = drop_q;
    out_valid_d = bus.out_valid;
    capture     = 1'b0;
    check       = (state_q == WAIT);
    align_set   = 1'b0;

    // Redirect wins over the sequential increment, even on a handshake.
    if (redirect_valid) begin
      pc_d      = {redirect_pc[ADDR_W-1:2], 2'b00};
      align_set = |redirect_pc[1:0];
    end else if (state_q == VALID && bus.out_ready) begin
      pc_d = pc_q + ADDR_W'(PC_INC);
    end

    case (state_q)
      FETCH: if (redirect_valid) drop_d = 1'b1;
      WAIT: begin
        // The squash only ever applies to the response of this one WAIT.
        drop_d  = 1'b0;
        capture = all_valid && !drop_q && !redirect_valid;
        if (capture) out_valid_d = 1'b1;
      end
      VALID: if (redirect_valid || bus.out_ready) out_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q            <= RESET_PC;
      drop_q          <= 1'b0;
      bus.out_valid   <= 1'b0;
      bus.out_pc      <= '0;
      bus.mem_rd_en   <= 1'b0;
      bus.mem_rd_addr <= '0;
      align_err       <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      drop_q        <= drop_d;
      bus.out_valid <= out_valid_d;
      bus.mem_rd_en <= (state_d == FETCH);
      if (capture)
        bus.out_pc <= pc_q;
      if (state_d == FETCH)
        bus.mem_rd_addr <= pc_d[ADDR_W-1:2];
      if (align_set)
        align_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed, table-driven bench for fetch_sequencer.
// A stub lane memory answers the address requested in the previous cycle.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [10:0] redirect_pc = '0;
  logic        lane_err, align_err;
  logic        rdy = 1'b0;
  logic [3:0]  mv = 4'h0;
  logic [8:0]  req_idx = '0;
  logic [31:0] mem_word;

  int n_cmp = 0;
  int n_err = 0;

  fetch_sequencer_if #(.ADDR_W(11)) bus ();

  fetch_sequencer #(.ADDR_W(11), .RESET_PC(11'h000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus),
    .lane_err       (lane_err),
    .align_err      (align_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [8:0] idx);
    logic [7:0] l;
    if (idx == 9'd0) return 32'hFFFF_FFFF;
    l = idx[7:0];
    return {l ^ 8'h80, 8'h00, l ^ 8'hC0, l};
  endfunction

  always @(posedge clk) if (bus.mem_rd_en) req_idx <= bus.mem_rd_addr;

  assign mem_word        = word_of(req_idx);
  assign bus.mem_data_b3 = mem_word[31:24];
  assign bus.mem_data_b2 = mem_word[23:16];
  assign bus.mem_data_b1 = mem_word[15:8];
  assign bus.mem_data_b0 = mem_word[7:0];
  assign bus.mem_valid   = mv;
  assign bus.out_ready   = rdy;

  typedef struct {
    logic        en, rv;
    logic [10:0] rpc;
    logic        rdy;
    logic [3:0]  mv;
    logic        e_rd_en;
    logic [8:0]  e_addr;
    logic        e_ov;
    logic [31:0] e_instr;
    logic [10:0] e_pc;
    logic        e_le, e_ae;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic e, rv, input logic [10:0] rpc,
                              input logic r, input logic [3:0] m,
                              input logic rd, input logic [8:0] a, input logic ov,
                              input logic [31:0] ins, input logic [10:0] pc,
                              input logic le, ae);
    vec_t v;
    v.en = e; v.rv = rv; v.rpc = rpc; v.rdy = r; v.mv = m;
    v.e_rd_en = rd; v.e_addr = a; v.e_ov = ov; v.e_instr = ins; v.e_pc = pc;
    v.e_le = le; v.e_ae = ae;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic rd, input logic [8:0] a,
                         input logic ov, input logic [31:0] ins, input logic [10:0] pc,
                         input logic le, input logic ae);
    chk({tag, ".mem_rd_en"},   32'(bus.mem_rd_en),   32'(rd));
    chk({tag, ".mem_rd_addr"}, 32'(bus.mem_rd_addr), 32'(a));
    chk({tag, ".out_valid"},   32'(bus.out_valid),   32'(ov));
    chk({tag, ".out_instr"},   bus.out_instr,        ins);
    chk({tag, ".out_pc"},      32'(bus.out_pc),      32'(pc));
    chk({tag, ".lane_err"},    32'(lane_err),        32'(le));
    chk({tag, ".align_err"},   32'(align_err),       32'(ae));
  endtask

  initial begin
    // en rv rpc rdy mv | rd_en addr ov instr pc le ae
    vq.push_back(mk(1,0,11'h000,0,4'hF, 1,9'h000,0,32'h0,        11'h000,0,0));
    vq.push_back(mk(1,0,11'h000,0,4'hF, 0,9'h000,0,32'h0,        11'h000,0,0));
    vq.push_back(mk(1,0,11'h000,0,4'hF, 0,9'h000,1,32'hFFFFFFFF, 11'h000,0,0));
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(1,0,11'h000,0,4'hF, 0,9'h000,1,32'hFFFFFFFF, 11'h000,0,0));
    vq.push_back(mk(1,0,11'h000,1,4'hF, 1,9'h001,0,32'hFFFFFFFF, 11'h000,0,0));
    vq.push_back(mk(1,1,11'h7E0,0,4'hF, 0,9'h001,0,32'hFFFFFFFF, 11'h000,0,0));
    vq.push_back(mk(1,0,11'h000,0,4'hF, 1,9'h1F8,0,32'hFFFFFFFF, 11'h000,0,0));
    vq.push_back(mk(1,0,11'h000,0,4'hF, 0,9'h1F8,0,32'hFFFFFFFF, 11'h000,0,0));
    vq.push_back(mk(1,0,11'h000,0,4'hF, 0,9'h1F8,1,32'h780038F8, 11'h7E0,0,0));
    vq.push_back(mk(1,1,11'h7E6,0,4'hF, 1,9'h1F9,0,32'h780038F8, 11'h7E0,0,1));
    vq.push_back(mk(1,0,11'h000,0,4'hF, 0,9'h1F9,0,32'h780038F8, 11'h7E0,0,1));
    vq.push_back(mk(1,0,11'h000,0,4'hB, 1,9'h1F9,0,32'h780038F8, 11'h7E0,1,1));
    vq.push_back(mk(1,0,11'h000,0,4'h0, 0,9'h1F9,0,32'h780038F8, 11'h7E0,1,1));
    vq.push_back(mk(1,0,11'h000,0,4'h0, 1,9'h1F9,0,32'h780038F8, 11'h7E0,1,1));
    vq.push_back(mk(1,0,11'h000,0,4'hF, 0,9'h1F9,0,32'h780038F8, 11'h7E0,1,1));
    vq.push_back(mk(1,0,11'h000,0,4'hF, 0,9'h1F9,1,32'h790039F9, 11'h7E4,1,1));
    vq.push_back(mk(1,0,11'h000,1,4'hF, 1,9'h1FA,0,32'h790039F9, 11'h7E4,1,1));
    vq.push_back(mk(1,1,11'h7FC,0,4'hF, 0,9'h1FA,0,32'h790039F9, 11'h7E4,1,1));
    vq.push_back(mk(1,0,11'h000,0,4'hF, 1,9'h1FF,0,32'h790039F9, 11'h7E4,1,1));
    vq.push_back(mk(1,0,11'h000,0,4'hF, 0,9'h1FF,0,32'h790039F9, 11'h7E4,1,1));
    vq.push_back(mk(1,0,11'h000,0,4'hF, 0,9'h1FF,1,32'h7F003FFF, 11'h7FC,1,1));
    vq.push_back(mk(1,0,11'h000,1,4'hF, 1,9'h000,0,32'h7F003FFF, 11'h7FC,1,1));
    vq.push_back(mk(0,0,11'h000,0,4'hF, 0,9'h000,0,32'h7F003FFF, 11'h7FC,1,1));
    vq.push_back(mk(0,0,11'h000,0,4'hF, 0,9'h000,1,32'hFFFFFFFF, 11'h000,1,1));
    vq.push_back(mk(0,0,11'h000,1,4'hF, 0,9'h000,0,32'hFFFFFFFF, 11'h000,1,1));
    vq.push_back(mk(0,0,11'h000,0,4'hF, 0,9'h000,0,32'hFFFFFFFF, 11'h000,1,1));
    vq.push_back(mk(1,0,11'h000,0,4'hF, 1,9'h001,0,32'hFFFFFFFF, 11'h000,1,1));
    vq.push_back(mk(1,0,11'h000,0,4'hF, 0,9'h001,0,32'hFFFFFFFF, 11'h000,1,1));
    vq.push_back(mk(1,0,11'h000,0,4'hF, 0,9'h001,1,32'h8100C101, 11'h004,1,1));
    vq.push_back(mk(1,1,11'h100,1,4'hF, 1,9'h040,0,32'h8100C101, 11'h004,1,1));
    vq.push_back(mk(1,0,11'h000,0,4'hF, 0,9'h040,0,32'h8100C101, 11'h004,1,1));
    vq.push_back(mk(1,0,11'h000,0,4'hF, 0,9'h040,1,32'hC0008040, 11'h100,1,1));

    // Reset state with clock running.
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 9'h000, 0, 32'h0, 11'h000, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      en             = vq[i].en;
      redirect_valid = vq[i].rv;
      redirect_pc    = vq[i].rpc;
      rdy            = vq[i].rdy;
      mv             = vq[i].mv;
      @(posedge clk);
      #1;
      chk_all($sformatf("row%0d", i), vq[i].e_rd_en, vq[i].e_addr, vq[i].e_ov,
              vq[i].e_instr, vq[i].e_pc, vq[i].e_le, vq[i].e_ae);
    end

    // Async reset while a word is held in VALID.
    redirect_valid = 1'b0;
    rdy            = 1'b0;
    en             = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 9'h000, 0, 32'h0, 11'h000, 0, 0);

    // After release, responses on the bus must not produce a word while IDLE.
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b0;
    mv    = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("idle%0d.out_valid", i), 32'(bus.out_valid), 32'd0);
      chk($sformatf("idle%0d.mem_rd_en", i), 32'(bus.mem_rd_en), 32'd0);
    end
    en = 1'b1;
    @(posedge clk);
    #1;
    chk("restart.mem_rd_en",   32'(bus.mem_rd_en),   32'd1);
    chk("restart.mem_rd_addr", 32'(bus.mem_rd_addr), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
